track_rom_arbiter: RTL and testbench
====================================

Name: track_rom_arbiter

Overview:
- Shares the single read port of the track tile BRAM between three requesters: the track_view video render pipeline, player kart physics and opponent kart physics.
- Physics needs terrain lookups at kart positions for off-track and collision checks.
- Video has absolute priority and a fixed, deterministic latency, so the render pipeline can compensate with a constant delay.
- Physics queries use valid/ready handshakes, are granted round-robin in cycles the video leaves idle, and return tagged responses.

Parameters:
ADDR_W, 14, track BRAM address width
DATA_W, 4, track tile/terrain code width
MEM_LATENCY, 2, BRAM read latency in cycles, from registered address to mem_data_in valid
STARVE_LIMIT, 1024, number of consecutive blocked cycles before a requester's starve flag sets

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-low
vid_req_in  input  1  video read request this cycle
vid_addr_in  input  ADDR_W  video read address
vid_valid_out  output  1  video read data valid
vid_data_out  output  DATA_W  video read data
p_req_valid_in  input  1  player query valid
p_req_addr_in  input  ADDR_W  player query address
p_req_ready_out  output  1  player query accepted this cycle
p_rsp_valid_out  output  1  player response valid (1-cycle pulse)
p_rsp_data_out  output  DATA_W  player response data
o_req_valid_in  input  1  opponent query valid
o_req_addr_in  input  ADDR_W  opponent query address
o_req_ready_out  output  1  opponent query accepted this cycle
o_rsp_valid_out  output  1  opponent response valid (1-cycle pulse)
o_rsp_data_out  output  DATA_W  opponent response data
mem_en_out  output  1  BRAM read enable
mem_addr_out  output  ADDR_W  BRAM address
mem_data_in  input  DATA_W  BRAM read data
starve_out  output  2  sticky starvation flags; bit0 player, bit1 opponent
stat_p_grants_out  output  16  player grant count (Optional Feature)
stat_o_grants_out  output  16  opponent grant count (Optional Feature)
stat_blocked_out  output  16  cycles with any query blocked (Optional Feature)

Behaviour:
- Reset (rst_in low on a clock edge): all outputs 0, tag pipeline cleared, wait counters 0, last_grant = opponent (so player wins the first tie). In-flight reads are discarded and produce no response.
- Grant is combinational per cycle:
  - vid_req_in high: both ready outputs 0; video owns the slot.
  - Otherwise only one query valid: that requester gets ready.
  - Otherwise both valid: grant goes to the requester other than last_grant.
  - last_grant updates only on a query grant; a video slot does not change it.
- Handshake:
  - Transfer occurs when valid && ready.
  - Requesters hold valid and addr stable until ready.
  - A requester may deassert valid before it is granted; no transfer occurs.
  - At most one transfer per cycle across all three requesters.
- Issue: the cycle-t winner's address is registered to mem_addr_out with mem_en_out=1 at t+1. mem_en_out=0 when no winner (mem_addr_out holds its last value).
- Tag pipeline: a 2-bit source tag (none/video/player/opponent) is shifted MEM_LATENCY+1 stages alongside the read.
- Response:
  - mem_data_in is registered into the tagged destination's data output at t+2+MEM_LATENCY. Default latency is 4 cycles from grant.
  - The matching valid pulses for exactly 1 cycle.
  - Non-target data outputs hold their previous value.
- Video latency is always exactly MEM_LATENCY+2 cycles, independent of query traffic.
- Back-to-back requests: every cycle may issue a read; responses return in issue order, one per cycle.
- Starvation:
  - A per-requester 11-bit saturating counter increments on cycles with valid && !ready and clears on grant or when valid is low.
  - When the counter reaches STARVE_LIMIT, the corresponding starve_out bit sets and stays set until reset.
  - The arbiter never stalls video to relieve starvation.
- Responses are never back-pressured; requesters must accept them.

Optional Feature:
- Macro: TRACK_ARB_STATS_EN.
- Defined: three 16-bit saturating counters.
  - stat_p_grants_out increments on each player transfer.
  - stat_o_grants_out increments on each opponent transfer.
  - stat_blocked_out increments each cycle in which any query valid is not granted.
  - All three clear on reset and hold at 16'hFFFF once saturated.
- Undefined: ports still exist and are tied to 0; no counter logic is generated.

Test Plan:
- Reset: hold rst_in=0 for 2 cycles with all requests high -> every output 0; after release, first tie grants player.
- Video only: vid_req_in=1 with vid_addr_in=0x0123 at cycle 10, mem_data_in model returns addr[3:0] -> mem_en_out=1 and mem_addr_out=0x0123 at cycle 11; vid_valid_out=1 and vid_data_out=0x3 at cycle 14; no query outputs toggle.
- Round-robin: player and opponent both valid continuously, vid_req_in=0 -> grants alternate P,O,P,O; responses return 4 cycles after each grant, tagged correctly with data matching the model.
- Video priority: vid_req_in=1 for 80 cycles while player is valid -> p_req_ready_out stays 0 throughout; player is granted the first cycle after video drops; video latency stays 4 every cycle.
- Starvation: STARVE_LIMIT=16, vid_req_in=1 continuously, opponent valid -> starve_out[1] sets after 16 blocked cycles and stays 1 after video drops and the opponent is granted; it clears only on reset.
- Reset mid-flight: grant player at cycle t, assert rst_in=0 at t+2 -> no p_rsp_valid_out pulse at t+4; with TRACK_ARB_STATS_EN defined, counters read 0 after reset.

Source files
------------

// File: rtl/track_rom_arbiter.sv
// track_rom_arbiter: shares the single track-tile BRAM read port between the
// video render pipeline (absolute priority, fixed MEM_LATENCY+2 latency) and
// two physics requesters (player/opponent) that are served round-robin in the
// slots video leaves idle and get tagged responses.
// Optional statistics counters are built when TRACK_ARB_STATS_EN is defined;
// otherwise the stat ports are tied to 0.
module track_rom_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 4,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              vid_req_in,
    input  logic [ADDR_W-1:0] vid_addr_in,
    output logic              vid_valid_out,
    output logic [DATA_W-1:0] vid_data_out,
    input  logic              p_req_valid_in,
    input  logic [ADDR_W-1:0] p_req_addr_in,
    output logic              p_req_ready_out,
    output logic              p_rsp_valid_out,
    output logic [DATA_W-1:0] p_rsp_data_out,
    input  logic              o_req_valid_in,
    input  logic [ADDR_W-1:0] o_req_addr_in,
    output logic              o_req_ready_out,
    output logic              o_rsp_valid_out,
    output logic [DATA_W-1:0] o_rsp_data_out,
    output logic              mem_en_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [1:0]        starve_out,
    output logic [15:0]       stat_p_grants_out,
    output logic [15:0]       stat_o_grants_out,
    output logic [15:0]       stat_blocked_out
);

    localparam logic [1:0]  TAG_NONE = 2'd0;
    localparam logic [1:0]  TAG_VID  = 2'd1;
    localparam logic [1:0]  TAG_P    = 2'd2;
    localparam logic [1:0]  TAG_O    = 2'd3;
    localparam logic [10:0] LIM      = 11'(STARVE_LIMIT);

    // Arbitration state: 1 = opponent was the last query granted.
    logic                      r_last_o;
    logic                      r_mem_en;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic [MEM_LATENCY:0][1:0] r_tag_pipe;

    logic              r_vid_valid, r_p_valid, r_o_valid;
    logic [DATA_W-1:0] r_vid_data, r_p_data, r_o_data;

    logic [1:0][10:0] r_wait;
    logic [1:0]       r_starve;

    logic              w_vid_go, w_p_ready, w_o_ready;
    logic [1:0]        w_tag;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_valid, w_ready;
    logic [1:0][10:0]  w_wait_nxt;

    // Per-cycle grant: video first, then the lone valid query, else the one
    // that did not win last time. Everything is gated off while in reset.
    always_comb begin
        w_vid_go  = rst_in & vid_req_in;
        w_p_ready = rst_in & ~vid_req_in & p_req_valid_in & (~o_req_valid_in | r_last_o);
        w_o_ready = rst_in & ~vid_req_in & o_req_valid_in & (~p_req_valid_in | ~r_last_o);
        w_tag     = TAG_NONE;
        w_addr    = vid_addr_in;
        if (w_vid_go) begin
            w_tag  = TAG_VID;
            w_addr = vid_addr_in;
        end else if (w_p_ready) begin
            w_tag  = TAG_P;
            w_addr = p_req_addr_in;
        end else if (w_o_ready) begin
            w_tag  = TAG_O;
            w_addr = o_req_addr_in;
        end
    end

    // Register the winner's address to the BRAM and shift its source tag
    // alongside the read so the data can be routed when it returns.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_last_o   <= 1'b1;
            r_tag_pipe <= '0;
        end else begin
            r_mem_en <= (w_tag != TAG_NONE);
            if (w_tag != TAG_NONE) r_mem_addr <= w_addr;
            if (w_p_ready)      r_last_o <= 1'b0;
            else if (w_o_ready) r_last_o <= 1'b1;
            r_tag_pipe[0] <= w_tag;
            for (int k = 1; k <= MEM_LATENCY; k++) r_tag_pipe[k] <= r_tag_pipe[k-1];
        end
    end

    // Route returning BRAM data to the tagged destination; others hold data.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_vid_valid <= 1'b0;
            r_p_valid   <= 1'b0;
            r_o_valid   <= 1'b0;
            r_vid_data  <= '0;
            r_p_data    <= '0;
            r_o_data    <= '0;
        end else begin
            r_vid_valid <= (r_tag_pipe[MEM_LATENCY] == TAG_VID);
            r_p_valid   <= (r_tag_pipe[MEM_LATENCY] == TAG_P);
            r_o_valid   <= (r_tag_pipe[MEM_LATENCY] == TAG_O);
            case (r_tag_pipe[MEM_LATENCY])
                TAG_VID: r_vid_data <= mem_data_in;
                TAG_P:   r_p_data   <= mem_data_in;
                TAG_O:   r_o_data   <= mem_data_in;
                default: ;
            endcase
        end
    end

    // Next wait count: saturating increment while blocked, clear otherwise.
    always_comb begin
        w_valid = {o_req_valid_in, p_req_valid_in};
        w_ready = {w_o_ready, w_p_ready};
        for (int g = 0; g < 2; g++) begin
            w_wait_nxt[g] = '0;
            if (w_valid[g] && !w_ready[g])
                w_wait_nxt[g] = (r_wait[g] == 11'h7FF) ? r_wait[g] : r_wait[g] + 11'd1;
        end
    end

    // Wait counters and sticky starvation flags (cleared only by reset).
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_wait   <= '0;
            r_starve <= '0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                r_wait[g] <= w_wait_nxt[g];
                if (w_wait_nxt[g] >= LIM) r_starve[g] <= 1'b1;
            end
        end
    end

`ifdef TRACK_ARB_STATS_EN
    logic [15:0] r_stat_p, r_stat_o, r_stat_blk;
    logic        w_blocked;

    assign w_blocked = |(w_valid & ~w_ready);

    // Saturating grant and blocked-cycle statistics.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_stat_p   <= '0;
            r_stat_o   <= '0;
            r_stat_blk <= '0;
        end else begin
            if (w_p_ready && r_stat_p != 16'hFFFF)   r_stat_p   <= r_stat_p + 16'd1;
            if (w_o_ready && r_stat_o != 16'hFFFF)   r_stat_o   <= r_stat_o + 16'd1;
            if (w_blocked && r_stat_blk != 16'hFFFF) r_stat_blk <= r_stat_blk + 16'd1;
        end
    end

    assign stat_p_grants_out = r_stat_p;
    assign stat_o_grants_out = r_stat_o;
    assign stat_blocked_out  = r_stat_blk;
`else
    assign stat_p_grants_out = 16'd0;
    assign stat_o_grants_out = 16'd0;
    assign stat_blocked_out  = 16'd0;
`endif

    assign p_req_ready_out = w_p_ready;
    assign o_req_ready_out = w_o_ready;
    assign mem_en_out      = r_mem_en;
    assign mem_addr_out    = r_mem_addr;
    assign vid_valid_out   = r_vid_valid;
    assign vid_data_out    = r_vid_data;
    assign p_rsp_valid_out = r_p_valid;
    assign p_rsp_data_out  = r_p_data;
    assign o_rsp_valid_out = r_o_valid;
    assign o_rsp_data_out  = r_o_data;
    assign starve_out      = r_starve;

endmodule

// File: tb/tb_track_rom_arbiter.sv
// Directed bench for track_rom_arbiter: reset, round-robin, video-only,
// video priority/latency, starvation and reset with a read in flight.
// BRAM model returns addr[3:0] two cycles after the registered address.
module tb_track_rom_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        vid_req_in;
    logic [13:0] vid_addr_in;
    logic        vid_valid_out;
    logic [3:0]  vid_data_out;
    logic        p_req_valid_in;
    logic [13:0] p_req_addr_in;
    logic        p_req_ready_out, p_rsp_valid_out;
    logic [3:0]  p_rsp_data_out;
    logic        o_req_valid_in;
    logic [13:0] o_req_addr_in;
    logic        o_req_ready_out, o_rsp_valid_out;
    logic [3:0]  o_rsp_data_out;
    logic        mem_en_out;
    logic [13:0] mem_addr_out;
    logic [3:0]  mem_data_in = 4'd0;
    logic [3:0]  m1 = 4'd0;
    logic [1:0]  starve_out;
    logic [15:0] stat_p_grants_out, stat_o_grants_out, stat_blocked_out;

    int n_asrt = 0;
    int n_fail = 0;

    track_rom_arbiter #(.ADDR_W(14), .DATA_W(4), .MEM_LATENCY(2), .STARVE_LIMIT(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .vid_req_in(vid_req_in), .vid_addr_in(vid_addr_in),
        .vid_valid_out(vid_valid_out), .vid_data_out(vid_data_out),
        .p_req_valid_in(p_req_valid_in), .p_req_addr_in(p_req_addr_in),
        .p_req_ready_out(p_req_ready_out), .p_rsp_valid_out(p_rsp_valid_out),
        .p_rsp_data_out(p_rsp_data_out),
        .o_req_valid_in(o_req_valid_in), .o_req_addr_in(o_req_addr_in),
        .o_req_ready_out(o_req_ready_out), .o_rsp_valid_out(o_rsp_valid_out),
        .o_rsp_data_out(o_rsp_data_out),
        .mem_en_out(mem_en_out), .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
        .starve_out(starve_out),
        .stat_p_grants_out(stat_p_grants_out), .stat_o_grants_out(stat_o_grants_out),
        .stat_blocked_out(stat_blocked_out)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model: two-cycle read latency, data = address low nibble.
    always @(posedge clk_in) begin
        m1          <= mem_addr_out[3:0];
        mem_data_in <= m1;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".p_ready"}, 32'(p_req_ready_out), 0);
        chk({tag, ".o_ready"}, 32'(o_req_ready_out), 0);
        chk({tag, ".mem_en"}, 32'(mem_en_out), 0);
        chk({tag, ".mem_addr"}, 32'(mem_addr_out), 0);
        chk({tag, ".vid_valid"}, 32'(vid_valid_out), 0);
        chk({tag, ".vid_data"}, 32'(vid_data_out), 0);
        chk({tag, ".p_rsp"}, 32'({p_rsp_valid_out, p_rsp_data_out}), 0);
        chk({tag, ".o_rsp"}, 32'({o_rsp_valid_out, o_rsp_data_out}), 0);
        chk({tag, ".starve"}, 32'(starve_out), 0);
        chk({tag, ".stats"}, 32'(stat_p_grants_out | stat_o_grants_out | stat_blocked_out), 0);
    endtask

    initial begin
        // Reset with every requester asserted.
        rst_in = 1'b0; vid_req_in = 1'b1; vid_addr_in = 14'h3FFF;
        p_req_valid_in = 1'b1; p_req_addr_in = 14'h0001;
        o_req_valid_in = 1'b1; o_req_addr_in = 14'h0002;
        step(); step(); #1;
        chk_all_zero("reset");

        // Round-robin: both valid for 8 cycles, player wins the first tie.
        for (int i = 0; i < 12; i++) begin
            step();
            rst_in = 1'b1; vid_req_in = 1'b0;
            p_req_valid_in = (i < 8);
            o_req_valid_in = (i < 8);
            p_req_addr_in  = 14'h010 + 14'((i + 1) / 2);
            o_req_addr_in  = 14'h028 + 14'(i / 2);
            #1;
            if (i < 8) begin
                chk("rr.p_ready", 32'(p_req_ready_out), 32'(i % 2 == 0));
                chk("rr.o_ready", 32'(o_req_ready_out), 32'(i % 2 == 1));
            end
            if (i >= 1 && i <= 8) begin
                chk("rr.mem_en", 32'(mem_en_out), 1);
                chk("rr.mem_addr", 32'(mem_addr_out),
                    ((i - 1) % 2 == 0) ? 32'(16 + (i - 1) / 2) : 32'(40 + (i - 1) / 2));
            end
            if (i == 9) chk("rr.mem_idle", 32'(mem_en_out), 0);
            if (i >= 4) begin
                if ((i - 4) % 2 == 0) begin
                    chk("rr.p_rsp", 32'({p_rsp_valid_out, p_rsp_data_out}), 32'(16 + (i - 4) / 2));
                    chk("rr.o_quiet", 32'(o_rsp_valid_out), 0);
                end else begin
                    chk("rr.o_rsp", 32'({o_rsp_valid_out, o_rsp_data_out}), 32'(16 + 8 + (i - 4) / 2));
                    chk("rr.p_quiet", 32'(p_rsp_valid_out), 0);
                end
            end
            chk("rr.vid_quiet", 32'(vid_valid_out), 0);
`ifdef TRACK_ARB_STATS_EN
            if (i == 8) begin
                chk("stat.p", 32'(stat_p_grants_out), 4);
                chk("stat.o", 32'(stat_o_grants_out), 4);
                chk("stat.blk", 32'(stat_blocked_out), 8);
            end
`else
            if (i == 8) chk("stat.tied", 32'(stat_p_grants_out | stat_o_grants_out | stat_blocked_out), 0);
`endif
        end

        // Single video read: address out next cycle, data 4 cycles after grant.
        step(); vid_req_in = 1'b1; vid_addr_in = 14'h0123; #1;
        chk("vid.no_ready", 32'({p_req_ready_out, o_req_ready_out}), 0);
        step(); vid_req_in = 1'b0; #1;
        chk("vid.mem", 32'({mem_en_out, mem_addr_out}), 32'h4123);
        step(); #1; chk("vid.early2", 32'(vid_valid_out), 0);
        step(); #1; chk("vid.early3", 32'(vid_valid_out), 0);
        step(); #1;
        chk("vid.rsp", 32'({vid_valid_out, vid_data_out}), 32'h13);
        chk("vid.q_quiet", 32'({p_rsp_valid_out, o_rsp_valid_out}), 0);
        step(); #1;
        chk("vid.pulse", 32'({vid_valid_out, vid_data_out}), 32'h03);
        chk("vid.p_hold", 32'(p_rsp_data_out), 3);
        chk("vid.o_hold", 32'(o_rsp_data_out), 4'hB);

        // Video for 80 cycles while player waits; player starves at 16.
        for (int j = 0; j <= 84; j++) begin
            step();
            vid_req_in = (j < 80); vid_addr_in = 14'(j);
            p_req_valid_in = (j <= 80); p_req_addr_in = 14'h00AB;
            #1;
            if (j < 80)  chk("pri.blocked", 32'(p_req_ready_out), 0);
            if (j == 80) chk("pri.granted", 32'(p_req_ready_out), 1);
            if (j == 81) chk("pri.mem", 32'({mem_en_out, mem_addr_out}), 32'h40AB);
            if (j >= 4 && j <= 83) chk("pri.vid_lat", 32'({vid_valid_out, vid_data_out}), 32'(16 + ((j - 4) & 15)));
            if (j == 84) begin
                chk("pri.vid_done", 32'(vid_valid_out), 0);
                chk("pri.p_rsp", 32'({p_rsp_valid_out, p_rsp_data_out}), 32'h1B);
            end
            if (j == 15) chk("pri.starve15", 32'(starve_out), 0);
            if (j == 16) chk("pri.starve16", 32'(starve_out), 1);
        end

        // Opponent starvation; flag stays after it is finally served.
        for (int j = 0; j <= 22; j++) begin
            step();
            vid_req_in = (j < 18); vid_addr_in = 14'h0;
            o_req_valid_in = (j <= 18); o_req_addr_in = 14'h00C5;
            #1;
            if (j < 18)  chk("ost.blocked", 32'(o_req_ready_out), 0);
            if (j == 15) chk("ost.starve15", 32'(starve_out), 1);
            if (j == 16) chk("ost.starve16", 32'(starve_out), 3);
            if (j == 18) chk("ost.granted", 32'(o_req_ready_out), 1);
            if (j == 22) begin
                chk("ost.o_rsp", 32'({o_rsp_valid_out, o_rsp_data_out}), 32'h15);
                chk("ost.sticky", 32'(starve_out), 3);
            end
        end

        // Reset two cycles after a player grant: no response may appear.
        step(); p_req_valid_in = 1'b1; p_req_addr_in = 14'h00E7; #1;
        chk("rmf.grant", 32'(p_req_ready_out), 1);
        step(); p_req_valid_in = 1'b0; #1;
        chk("rmf.issue", 32'({mem_en_out, mem_addr_out}), 32'h40E7);
        step(); rst_in = 1'b0;
        step(); rst_in = 1'b1; #1;
        chk_all_zero("rmf.after");
        step(); #1;
        chk("rmf.no_rsp4", 32'({p_rsp_valid_out, p_rsp_data_out}), 0);
        step(); #1;
        chk("rmf.no_rsp5", 32'({p_rsp_valid_out, p_rsp_data_out}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
